// File: rtl/computer_loader.sv
// Host-side loader for the 4-bit computer: streams program words into its
// instruction/data memories, pads with HLT, then runs it and captures d_out.
module computer_loader #(
  parameter int unsigned RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_ins,
  input  logic [3:0]       s_data,
  input  logic             s_last,
  output logic             cpu_rst,
  output logic [3:0]       cpu_ins_address,
  output logic [7:0]       cpu_ins,
  output logic [3:0]       cpu_d_in,
  input  logic [3:0]       cpu_d_out,
  output logic [3:0]       result,
  output logic             done
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned INS_W  = 8;
  localparam int unsigned DATA_W = 4;

  localparam logic [INS_W-1:0]  HLT_INS   = 8'h0F;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [RUN_W-1:0]    r_budget;
  logic [RUN_W-1:0]    r_run_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [INS_W-1:0]    r_ins;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   r_result;
  logic                r_done;
  logic                r_s_ready;
  logic                r_cpu_rst;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [RUN_W-1:0]    w_budget_nxt;
  logic [RUN_W-1:0]    w_run_cnt_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [INS_W-1:0]    w_ins_nxt;
  logic [DATA_W-1:0]   w_din_nxt;
  logic [DATA_W-1:0]   w_result_nxt;
  logic                w_done_nxt;
  logic                w_s_ready_nxt;
  logic                w_cpu_rst_nxt;
  logic                w_hs;
  logic [RUN_W-1:0]    w_budget_min1;

  assign w_hs          = s_valid && r_s_ready;
  // A zero budget still runs the computer for one cycle.
  assign w_budget_min1 = (r_budget == '0) ? RUN_W'(1) : r_budget;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_budget_nxt  = r_budget;
    w_run_cnt_nxt = r_run_cnt;
    w_addr_nxt    = r_addr;
    w_ins_nxt     = r_ins;
    w_din_nxt     = r_din;
    w_result_nxt  = r_result;
    w_done_nxt    = r_done;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_budget_nxt = run_cycles;
          w_cnt_nxt    = '0;
          w_done_nxt   = 1'b0;
          w_state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_addr_nxt = r_cnt;
          w_ins_nxt  = s_ins;
          w_din_nxt  = s_data;
          w_cnt_nxt  = r_cnt + ADDR_W'(1);
          if (r_cnt == LAST_ADDR) begin
            w_state_nxt = ST_SETTLE;
          end else if (s_last) begin
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        w_addr_nxt = r_cnt;
        w_ins_nxt  = HLT_INS;
        w_din_nxt  = '0;
        w_cnt_nxt  = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_run_cnt_nxt = w_budget_min1;
        w_state_nxt   = ST_RUN;
      end
      ST_RUN: begin
        if (r_run_cnt <= RUN_W'(1)) begin
          w_result_nxt = cpu_d_out;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_run_cnt_nxt = r_run_cnt - RUN_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Handshake and computer reset follow the state being entered.
    w_s_ready_nxt = (w_state_nxt == ST_LOAD);
    w_cpu_rst_nxt = !((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_budget  <= '0;
      r_run_cnt <= '0;
      r_addr    <= '0;
      r_ins     <= HLT_INS;
      r_din     <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_s_ready <= 1'b0;
      r_cpu_rst <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_budget  <= w_budget_nxt;
      r_run_cnt <= w_run_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_ins     <= w_ins_nxt;
      r_din     <= w_din_nxt;
      r_result  <= w_result_nxt;
      r_done    <= w_done_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_cpu_rst <= w_cpu_rst_nxt;
    end
  end

  assign s_ready         = r_s_ready;
  assign cpu_rst         = r_cpu_rst;
  assign cpu_ins_address = r_addr;
  assign cpu_ins         = r_ins;
  assign cpu_d_in        = r_din;
  assign result          = r_result;
  assign done            = r_done;

endmodule

// File: tb/tb_computer_loader.sv
// Directed bench for computer_loader with a toy computer model
// (LDI=5, INC=4, HLT=F, others NOP; d_out is the accumulator).
module tb_computer_loader;

  localparam int unsigned RUN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [RUN_W-1:0] run_cycles;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_ins;
  logic [3:0]       s_data;
  logic             s_last;
  logic             cpu_rst;
  logic [3:0]       cpu_ins_address;
  logic [7:0]       cpu_ins;
  logic [3:0]       cpu_d_in;
  logic [3:0]       cpu_d_out;
  logic [3:0]       result;
  logic             done;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  computer_loader #(.RUN_W(RUN_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .run_cycles      (run_cycles),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_ins           (s_ins),
    .s_data          (s_data),
    .s_last          (s_last),
    .cpu_rst         (cpu_rst),
    .cpu_ins_address (cpu_ins_address),
    .cpu_ins         (cpu_ins),
    .cpu_d_in        (cpu_d_in),
    .cpu_d_out       (cpu_d_out),
    .result          (result),
    .done            (done)
  );

  // Toy computer: memories written every negedge, executes on posedge out of reset.
  logic [7:0] mem_ins [16];
  logic [3:0] mem_d   [16];
  logic [3:0] ip;
  logic [3:0] acc;
  logic       por;
  logic [7:0] cur_ins;

  assign cur_ins   = mem_ins[ip];
  assign cpu_d_out = acc;

  always @(negedge clk) begin
    mem_ins[cpu_ins_address] <= cpu_ins;
    mem_d[cpu_ins_address]   <= cpu_d_in;
  end

  always @(posedge clk) begin
    if (por) begin
      ip  <= 4'h0;
      acc <= 4'h0;
    end else if (!cpu_rst) begin
      case (cur_ins[3:0])
        4'hF: ip <= ip;
        4'h5: begin acc <= cur_ins[7:4]; ip <= ip + 4'd1; end
        4'h4: begin acc <= acc + 4'd1;   ip <= ip + 4'd1; end
        default: ip <= ip + 4'd1;
      endcase
    end
  end

  logic [7:0] prog_a [3] = '{8'h05, 8'h04, 8'h0F};

  function automatic logic [7:0] w16(input int i);
    if (i == 4)  return 8'h0F;
    if (i == 15) return 8'hA4;
    return 8'h04;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int ncyc, output int nrun);
    ncyc = 0;
    nrun = 0;
    while (!done && ncyc < 200) begin
      if (!cpu_rst) nrun++;
      tick();
      ncyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic chk_mem_prog_a(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk(tag, {20'd0, mem_ins[i], mem_d[i]},
          (i < 3) ? {20'd0, prog_a[i], 4'(i + 1)} : {20'd0, 8'h0F, 4'h0});
    end
  endtask

  task automatic load_prog_a();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_ins   = prog_a[i];
      s_data  = 4'(i + 1);
      s_last  = (i == 2);
      tick();
      chk("load_a_port", {16'd0, cpu_ins_address, cpu_ins, cpu_d_in},
          {16'd0, 4'(i), prog_a[i], 4'(i + 1)});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ncyc;
    int nrun;
    por = 1'b1; rst_n = 1'b0; start = 1'b0; run_cycles = '0;
    s_valid = 1'b0; s_ins = 8'h00; s_data = 4'h0; s_last = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_result",  32'(result),  32'd0);
    chk("rst_port", {16'd0, cpu_ins_address, cpu_ins, cpu_d_in}, {16'd0, 4'h0, 8'h0F, 4'h0});
    por = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_s_ready", 32'(s_ready), 32'd0);

    // Short program, run 10, with an ignored start pulse during RUN
    start = 1'b1; run_cycles = 8'd10;
    tick();
    start = 1'b0;
    chk("t1_load_ready", {30'd0, s_ready, cpu_rst}, {30'd0, 1'b1, 1'b1});
    load_prog_a();
    chk("t1_fill_ready", 32'(s_ready), 32'd0);
    repeat (13) tick();
    chk("t1_settle", {15'd0, cpu_rst, cpu_ins_address, cpu_ins, cpu_d_in}, {15'd0, 1'b1, 4'hF, 8'h0F, 4'h0});
    tick();
    for (int i = 1; i <= 10; i++) begin
      chk("t1_run", {14'd0, done, cpu_rst, cpu_ins_address, cpu_ins, cpu_d_in},
          {14'd0, 1'b0, 1'b0, 4'hF, 8'h0F, 4'h0});
      if (i == 5) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("t1_done",   32'(done),   32'd1);
    chk("t1_result", 32'(result), 32'h1);
    chk("t1_done_rst", {30'd0, cpu_rst, s_ready}, 32'd0);
    chk_mem_prog_a("t1_mem");

    // Restart from DONE, s_valid on alternate cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_restart", {30'd0, done, s_ready}, {30'd0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b0;
      tick();
      chk("t2_hold_addr", 32'(cpu_ins_address), (i == 0) ? 32'hF : 32'(i - 1));
      s_valid = 1'b1;
      s_ins   = prog_a[i];
      s_data  = 4'(i + 1);
      s_last  = (i == 2);
      tick();
      chk("t2_addr", {16'd0, cpu_ins_address, cpu_ins, cpu_d_in}, {16'd0, 4'(i), prog_a[i], 4'(i + 1)});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_done(ncyc, nrun);
    chk("t2_cycles", 32'(ncyc), 32'd24);
    chk("t2_result", 32'(result), 32'h1);
    chk_mem_prog_a("t2_mem");

    // Full 16-word load, no FILL, 17th word refused
    start = 1'b1; run_cycles = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t3_ready", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_ins   = w16(i);
      s_data  = 4'(i);
      s_last  = 1'b0;
      tick();
      chk("t3_addr", 32'(cpu_ins_address), 32'(i));
    end
    chk("t3_settle", {30'd0, s_ready, cpu_rst}, {30'd0, 1'b0, 1'b1});
    s_ins  = 8'h33;
    s_data = 4'h3;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3_run_port", {14'd0, s_ready, cpu_rst, cpu_ins_address, cpu_ins, cpu_d_in},
          {14'd0, 1'b0, 1'b0, 4'hF, 8'hA4, 4'hF});
      tick();
    end
    s_valid = 1'b0;
    chk("t3_done",   32'(done),   32'd1);
    chk("t3_result", 32'(result), 32'h3);
    for (int i = 0; i < 16; i++) begin
      chk("t3_mem", {20'd0, mem_ins[i], mem_d[i]}, {20'd0, w16(i), 4'(i)});
    end

    // Reset mid-LOAD at address 5, then reload with run_cycles=0
    start = 1'b1; run_cycles = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_ins   = 8'(8'h10 + i);
      s_data  = 4'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("t4_addr5", 32'(cpu_ins_address), 32'h5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_rst_ctl", {28'd0, cpu_rst, s_ready, done, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("t4_rst_result", 32'(result), 32'd0);
    chk("t4_rst_port", {16'd0, cpu_ins_address, cpu_ins, cpu_d_in}, {16'd0, 4'h0, 8'h0F, 4'h0});
    @(negedge clk);
    #1;
    chk("t4_mem0_hlt", {20'd0, mem_ins[0], mem_d[0]}, {20'd0, 8'h0F, 4'h0});
    tick();
    chk("t4_idle_ready", 32'(s_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_reload_ready", 32'(s_ready), 32'd1);
    load_prog_a();
    wait_done(ncyc, nrun);
    chk("t4_run_len", 32'(nrun), 32'd1);
    chk("t4_cycles",  32'(ncyc), 32'd15);
    chk("t4_result",  32'(result), 32'h3);
    chk_mem_prog_a("t4_mem");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
